ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

Parametrised AHB-Lite SRAM slave: next-generation on-chip memory target on the system bus, replacing the fixed 32-bit, fixed-latency memory model. It adds configurable data width and depth, independent NONSEQ/SEQ wait-state counts, byte/halfword sub-word writes from HSIZE, and a proper two-cycle ERROR response for illegal accesses. It sits behind the bus decoder/mux and exposes HREADYOUT for the interconnect to combine into HREADY.

## Interface
- DATA_WIDTH, 32: bus data width; legal 32 or 64
- MEM_DEPTH, 256: words of DATA_WIDTH; need not be a power of two
- NONSEQ_WAIT, 2: wait states inserted on NONSEQ transfers; 0 legal
- SEQ_WAIT, 0: wait states inserted on SEQ transfers; 0 legal
- HCLK  in  1  bus clock; all state on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  slave select from decoder
- HADDR  in  32  byte address (address phase)
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1=write
- HSIZE  in  3  log2(bytes): 0=byte, 1=half, 2=word, 3=dword
- HWDATA  in  DATA_WIDTH  write data (data phase)
- HREADY  in  1  bus-level ready; address phase sampled only when 1
- HREADYOUT  out  1  slave ready; 0 inserts a wait state
- HRESP  out  2  00=OKAY, 01=ERROR
- HRDATA  out  DATA_WIDTH  read data, valid when completing read

## Operation
- BYTES = DATA_WIDTH/8; LSB = log2(BYTES); word index = HADDR >> LSB; byte lane = HADDR[LSB-1:0]; little-endian.
- Address phase accepted when HSEL & HTRANS[1] & HREADY; captures addr, write, size, trans type. IDLE/BUSY or !HSEL → zero-wait OKAY, no access.
- Error check at acceptance: word index >= MEM_DEPTH, or HSIZE > LSB, or HADDR & ((1<<HSIZE)-1) != 0 (misaligned). Any → error path, memory untouched.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=OKAY. On legal accept: wait = NONSEQ_WAIT or SEQ_WAIT per captured type; wait>0 → WAIT, else stay IDLE with data phase pending (completes next cycle). On illegal accept → ERR1.
  - WAIT: HREADYOUT=0; counter decrements each cycle; at 0 the next cycle is the completing cycle (HREADYOUT=1).
  - ERR1: HREADYOUT=0, HRESP=ERROR, → ERR2. ERR2: HREADYOUT=1, HRESP=ERROR, → IDLE (a new address phase presented in ERR2 is accepted normally).
- Completing cycle of a write: bytes selected by strobe (size, lane) from HWDATA written at the closing edge; unselected bytes preserved.
- Completing cycle of a read: HRDATA = full addressed word (all lanes); master selects lanes. HRDATA = 0 in all other cycles.
- Pipelining: a new address phase is accepted in the same cycle the previous data phase completes; back-to-back zero-wait transfers give one transfer per cycle.
- Counter width $clog2(max(NONSEQ_WAIT,SEQ_WAIT)+1), minimum 1 bit.
- Memory contents not reset; undefined until written.

## Timing
- Reset (async assert, sync-released use): HREADYOUT=1, HRESP=00, HRDATA=0, FSM=IDLE, no pending transfer.
- Reset mid-transfer: pending data phase abandoned; no write occurs, outputs to reset values immediately.
- Read latency: address phase at cycle N → data at cycle N+1+wait.
- Write committed at end of cycle N+1+wait; a read to the same address whose address phase is in that completing cycle returns the new data.
- HRESP=ERROR lasts exactly two cycles, first with HREADYOUT=0.
- HWDATA sampled only in the completing cycle; ignored during wait cycles.

## Test plan
- Reset: hold HRESETn=0 → HREADYOUT=1, HRESP=00, HRDATA=0; assert reset during WAIT of a write to 0x10 → word 4 unchanged afterward.
- NONSEQ_WAIT=2, write 0xDEADBEEF to 0x20 then NONSEQ read 0x20 → two HREADYOUT=0 cycles each, HRDATA=0xDEADBEEF on read completion.
- Byte/halfword writes (DATA_WIDTH=32): word 0x0 = 0x11223344; byte write 0xAA to 0x1, half write 0xBBBB at 0x2 → read 0xBBBBAA44.
- SEQ burst with SEQ_WAIT=0: NONSEQ 0x40 then SEQ 0x44,0x48,0x4C reads → 2 waits on first beat, then one beat per cycle, data correct.
- Errors: read 0x400 with MEM_DEPTH=256, word access at 0x2, HSIZE=3 at DATA_WIDTH=32 → each gives HRESP=01 for 2 cycles (HREADYOUT 0 then 1), memory unchanged.
- Idle/unselected: HTRANS=IDLE or HSEL=0 with HWRITE=1 → HREADYOUT=1, HRESP=00, no memory change.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable width/depth, separate NONSEQ/SEQ wait
// states, sub-word writes and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned NONSEQ_WAIT = 2,
  parameter int unsigned SEQ_WAIT    = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned MAXW  = (NONSEQ_WAIT > SEQ_WAIT) ? NONSEQ_WAIT : SEQ_WAIT;
  localparam int unsigned CW    = (MAXW > 0) ? $clog2(MAXW + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pend_q, pend_d;
  logic           wr_q, wr_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [LSB-1:0] lane_q, lane_d;
  logic [2:0]     size_q, size_d;

  logic              accept;
  logic              illegal;
  logic              complete;
  logic [31:0]       word_idx;
  logic [31:0]       wait_sel;
  logic [BYTES-1:0]  strb;

  // Address-phase decode and legality check
  always_comb begin
    word_idx = HADDR >> LSB;
    accept   = HSEL && HTRANS[1] && HREADY &&
               ((state_q == S_IDLE) || (state_q == S_ERR2));
    illegal  = (word_idx >= 32'(MEM_DEPTH)) ||
               (HSIZE > 3'(LSB)) ||
               ((HADDR & ((32'd1 << HSIZE) - 32'd1)) != 32'd0);
    wait_sel = HTRANS[0] ? 32'(SEQ_WAIT) : 32'(NONSEQ_WAIT);
    complete = pend_q && (state_q == S_IDLE);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;

    case (state_q)
      S_IDLE: if (complete) pend_d = 1'b0;
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_ERR1: state_d = S_ERR2;
      S_ERR2: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new address phase may overlap the cycle that closes the previous one
    if (accept) begin
      if (illegal) begin
        state_d = S_ERR1;
        pend_d  = 1'b0;
      end else begin
        pend_d = 1'b1;
        wr_d   = HWRITE;
        idx_d  = AW'(word_idx);
        lane_d = HADDR[LSB-1:0];
        size_d = HSIZE;
        if (wait_sel != 32'd0) begin
          state_d = S_WAIT;
          cnt_d   = CW'(wait_sel - 32'd1);
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
    end
  end

  // Byte strobe: 2**size contiguous lanes starting at the captured lane
  always_comb begin
    strb = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if ((32'(b) >= 32'(lane_q)) && (32'(b) < 32'(lane_q) + (32'd1 << size_q)))
        strb[b] = 1'b1;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge HCLK) begin
    if (complete && wr_q) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (strb[b]) mem[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
      end
    end
  end

  always_comb begin
    HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
    HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
    HRDATA    = (complete && !wr_q) ? mem[idx_q] : '0;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomised scoreboard bench for ahb_sram_slave: the driver pushes expected
// responses from a byte-level memory model; a monitor checks each data phase.
module tb_ahb_sram_slave;

  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 256;
  localparam int unsigned NSW = 2;
  localparam int unsigned SW  = 0;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [DW-1:0] HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic [1:0]    HRESP;
  logic [DW-1:0] HRDATA;

  ahb_sram_slave #(
    .DATA_WIDTH(DW), .MEM_DEPTH(DEP), .NONSEQ_WAIT(NSW), .SEQ_WAIT(SW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
    logic [31:0] mask;
    int          waits;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_cur;
  logic [7:0] mem_b [0:DEP*4-1];
  bit         known [0:DEP*4-1];
  int         checks = 0;
  int         errors = 0;
  bit         dphase = 1'b0;
  int         wcnt = 0;
  logic [1:0] low_resp = 2'b00;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: legality, wait count and byte-level memory image
  task automatic model_accept(input logic [31:0] a, input bit w, input logic [2:0] sz,
                              input logic [1:0] tr, input logic [31:0] wd);
    exp_t        e;
    int unsigned ai;
    int unsigned nb;
    int unsigned base;
    bit          legal;
    ai    = a;
    nb    = 1 << sz;
    legal = (ai < DEP * 4) && (sz <= 3'd2) && ((ai % nb) == 0);
    e.err   = !legal;
    e.rd    = !w;
    e.data  = '0;
    e.mask  = '0;
    e.waits = !legal ? 1 : ((tr == 2'b11) ? int'(SW) : int'(NSW));
    if (legal && w) begin
      for (int unsigned k = 0; k < nb; k++) begin
        mem_b[ai + k] = wd[8 * ((ai % 4) + k) +: 8];
        known[ai + k] = 1'b1;
      end
    end
    if (legal && !w) begin
      base = ai - (ai % 4);
      for (int unsigned k = 0; k < 4; k++) begin
        e.data[8*k +: 8] = mem_b[base + k];
        if (known[base + k]) e.mask[8*k +: 8] = 8'hFF;
      end
    end
    exp_q.push_back(e);
  endtask

  // Present an address phase (called at posedge+1); returns once it is accepted
  task automatic xfer(input logic [31:0] a, input bit w, input logic [2:0] sz,
                      input logic [1:0] tr, input logic [31:0] wd);
    int n;
    HSEL = 1'b1; HADDR = a; HTRANS = tr; HWRITE = w; HSIZE = sz;
    n = 0;
    @(negedge HCLK);
    while (!HREADY && n < 40) begin
      n++;
      @(negedge HCLK);
    end
    if (!HREADY) chk(1'b0, "accept_timeout", 64'(HREADY), 64'd1);
    @(posedge HCLK);
    model_accept(a, w, sz, tr, wd);
    #1;
    HWDATA = wd;
    HTRANS = 2'b00;
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin
      HSEL   = 1'($urandom_range(0, 1));
      HTRANS = 2'($urandom_range(0, 1));
      HWRITE = 1'b1;
      HADDR  = $urandom_range(0, 255);
      @(posedge HCLK); #1;
    end
    HTRANS = 2'b00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    HTRANS = 2'b00;
    while ((exp_q.size() != 0 || dphase) && n < 60) begin
      n++;
      @(posedge HCLK); #1;
    end
    if (exp_q.size() != 0 || dphase) chk(1'b0, "drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: classify each cycle as idle, wait or completing data phase
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      chk({HREADYOUT, HRESP, HRDATA} == {1'b1, 2'b00, 32'd0}, "reset_outputs",
          64'({HREADYOUT, HRESP, HRDATA}), 64'({1'b1, 2'b00, 32'd0}));
      dphase = 1'b0;
      wcnt   = 0;
      exp_q.delete();
    end else begin
      if (dphase) begin
        if (!HREADYOUT) begin
          if (wcnt == 0) low_resp = HRESP;
          wcnt++;
          chk(HRDATA == '0, "wait_rdata", 64'(HRDATA), 64'd0);
          if (wcnt > 40) begin
            chk(1'b0, "wait_timeout", 64'(wcnt), 64'd40);
            dphase = 1'b0;
            wcnt   = 0;
          end
        end else begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_completion", 64'(HRESP), 64'd0);
          end else begin
            e_cur = exp_q.pop_front();
            chk(wcnt == e_cur.waits, "wait_count", 64'(wcnt), 64'(e_cur.waits));
            chk(HRESP == (e_cur.err ? 2'b01 : 2'b00), "hresp_final",
                64'(HRESP), 64'(e_cur.err ? 2'b01 : 2'b00));
            if (wcnt > 0)
              chk(low_resp == (e_cur.err ? 2'b01 : 2'b00), "hresp_first",
                  64'(low_resp), 64'(e_cur.err ? 2'b01 : 2'b00));
            if (e_cur.rd && !e_cur.err)
              chk(((HRDATA ^ e_cur.data) & e_cur.mask) == 32'd0, "rdata",
                  64'(HRDATA & e_cur.mask), 64'(e_cur.data & e_cur.mask));
            else
              chk(HRDATA == '0, "rdata_zero", 64'(HRDATA), 64'd0);
          end
          dphase = 1'b0;
          wcnt   = 0;
        end
      end else begin
        chk({HREADYOUT, HRESP, HRDATA} == {1'b1, 2'b00, 32'd0}, "idle_outputs",
            64'({HREADYOUT, HRESP, HRDATA}), 64'({1'b1, 2'b00, 32'd0}));
      end
      if (!dphase) dphase = HSEL && HTRANS[1] && HREADY;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    for (int i = 0; i < DEP * 4; i++) known[i] = 1'b0;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00;
    HWRITE = 1'b0; HSIZE = 3'd2; HWDATA = '0;
    repeat (3) @(posedge HCLK);
    #2 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Reset during the wait states of a write leaves memory untouched
    xfer(32'h10, 1'b1, 3'd2, 2'b10, 32'h12345678);
    drain();
    HSEL = 1'b1; HADDR = 32'h10; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HTRANS = 2'b00; HWDATA = 32'hFFFFFFFF;
    @(posedge HCLK); #2;
    HRESETn = 1'b0;
    @(posedge HCLK); #2;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    xfer(32'h10, 1'b0, 3'd2, 2'b10, 32'h0);

    // Word write/read-back with NONSEQ wait states
    xfer(32'h20, 1'b1, 3'd2, 2'b10, 32'hDEADBEEF);
    xfer(32'h20, 1'b0, 3'd2, 2'b10, 32'h0);

    // Sub-word writes with junk on unselected lanes
    xfer(32'h0, 1'b1, 3'd2, 2'b10, 32'h11223344);
    xfer(32'h1, 1'b1, 3'd0, 2'b10, 32'h5555AA55);
    xfer(32'h2, 1'b1, 3'd1, 2'b10, 32'hBBBB1234);
    xfer(32'h0, 1'b0, 3'd2, 2'b10, 32'h0);

    // Sequential burst: waits on the first beat only
    for (int i = 0; i < 4; i++)
      xfer(32'h40 + 32'(4 * i), 1'b1, 3'd2, (i == 0) ? 2'b10 : 2'b11, 32'hA0B0C000 + 32'(i));
    for (int i = 0; i < 4; i++)
      xfer(32'h40 + 32'(4 * i), 1'b0, 3'd2, (i == 0) ? 2'b10 : 2'b11, 32'h0);

    // Illegal accesses: out of range, misaligned, oversize
    xfer(32'h8, 1'b1, 3'd2, 2'b10, 32'hCAFEF00D);
    xfer(32'h400, 1'b0, 3'd2, 2'b10, 32'h0);
    xfer(32'h2, 1'b1, 3'd2, 2'b10, 32'hFFFFFFFF);
    xfer(32'h8, 1'b1, 3'd3, 2'b10, 32'hFFFFFFFF);
    xfer(32'h0, 1'b0, 3'd2, 2'b10, 32'h0);
    xfer(32'h8, 1'b0, 3'd2, 2'b10, 32'h0);

    // Idle and unselected cycles must not write
    drain();
    HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h0; HSIZE = 3'd2; HWDATA = 32'hFFFFFFFF;
    repeat (3) begin @(posedge HCLK); #1; end
    HSEL = 1'b0; HTRANS = 2'b10;
    repeat (3) begin @(posedge HCLK); #1; end
    HTRANS = 2'b00;
    xfer(32'h0, 1'b0, 3'd2, 2'b10, 32'h0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1000, 1100)) : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 8) a = a & ~((32'd1 << sz) - 32'd1);
      xfer(a, 1'($urandom_range(0, 1)), sz, $urandom_range(0, 1) ? 2'b11 : 2'b10, $urandom);
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
    end

    drain();
    repeat (2) @(posedge HCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
